// File: rtl/alu_operand_regfile.sv
// Operand register file for the ALU. It has two registered read ports and one synchronous write port.
// Define RF_BYPASS_EN to forward same-cycle write data to a read port whose address matches the write address.
module alu_operand_regfile #(
  parameter  int BW     = 16,
  parameter  int N_REGS = 8,
  localparam int ADDR_W = $clog2(N_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     write_en,
  input  logic        [ADDR_W-1:0] write_addr,
  input  logic signed [BW-1:0]     write_data,
  input  logic                     read_en,
  input  logic        [ADDR_W-1:0] read_addr_a,
  input  logic        [ADDR_W-1:0] read_addr_b,
  output logic signed [BW-1:0]     out_a,
  output logic signed [BW-1:0]     out_b
);

  logic signed [BW-1:0] mem [N_REGS];
  logic signed [BW-1:0] rd_a;
  logic signed [BW-1:0] rd_b;
  logic                 wr_ok;

  // When N_REGS is not a power of two, the address space contains indices with no register behind them.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return int'(addr) < N_REGS;
  endfunction

  assign wr_ok = write_en && in_range(write_addr);

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (in_range(read_addr_a)) rd_a = mem[read_addr_a];
    if (in_range(read_addr_b)) rd_b = mem[read_addr_b];
`ifdef RF_BYPASS_EN
    if (wr_ok && (read_addr_a == write_addr)) rd_a = write_data;
    if (wr_ok && (read_addr_b == write_addr)) rd_b = write_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem   <= '{default: '0};
      out_a <= '0;
      out_b <= '0;
    end else begin
      if (wr_ok) mem[write_addr] <= write_data;
      if (read_en) begin
        out_a <= rd_a;
        out_b <= rd_b;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_regfile.sv
// Directed, table-driven bench for alu_operand_regfile. The DUT is built with N_REGS = 6 so the out-of-range addresses 6 and 7 exist.
module tb_alu_operand_regfile;

  localparam int BW     = 16;
  localparam int N_REGS = 6;
  localparam int AW     = 3;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 write_en;
  logic        [AW-1:0] write_addr;
  logic signed [BW-1:0] write_data;
  logic                 read_en;
  logic        [AW-1:0] read_addr_a;
  logic        [AW-1:0] read_addr_b;
  logic signed [BW-1:0] out_a;
  logic signed [BW-1:0] out_b;

  int errors = 0;
  int checks = 0;

  alu_operand_regfile #(.BW(BW), .N_REGS(N_REGS)) dut (
    .clk(clk), .rst_n(rst_n), .write_en(write_en), .write_addr(write_addr),
    .write_data(write_data), .read_en(read_en), .read_addr_a(read_addr_a),
    .read_addr_b(read_addr_b), .out_a(out_a), .out_b(out_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst_n;
    logic          we;
    logic [AW-1:0] wa;
    logic [BW-1:0] wd;
    logic          re;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [BW-1:0] ea;
    logic [BW-1:0] eb;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge. Outputs are sampled at that same point, after the edge has taken effect.
  task automatic step(input logic r, input logic we, input logic [AW-1:0] wa, input logic [BW-1:0] wd,
                      input logic re, input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    rst_n = r; write_en = we; write_addr = wa; write_data = wd;
    read_en = re; read_addr_a = ra; read_addr_b = rb;
    @(posedge clk);
    #1;
  endtask

  logic [BW-1:0] exp_rb [N_REGS];
  logic [BW-1:0] sum;
  logic [BW-1:0] exp_same;

  initial begin
`ifdef RF_BYPASS_EN
    exp_same = 16'h0055;
`else
    exp_same = 16'h00AA;
`endif
    //           rst  we  wa    wd        re  ra    rb    exp_a     exp_b
    vecs[0]  = '{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b1, 1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000};
    vecs[2]  = '{1'b0, 1'b1, 3'd5, 16'h7777, 1'b1, 3'd3, 3'd5, 16'h0000, 16'h0000};
    vecs[3]  = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 3'd5, 16'h0000, 16'h0000};
    vecs[4]  = '{1'b1, 1'b1, 3'd1, 16'h7FFF, 1'b0, 3'd1, 3'd2, 16'h0000, 16'h0000};
    vecs[5]  = '{1'b1, 1'b1, 3'd2, 16'h8000, 1'b0, 3'd1, 3'd2, 16'h0000, 16'h0000};
    vecs[6]  = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 3'd2, 16'h7FFF, 16'h8000};
    vecs[7]  = '{1'b1, 1'b1, 3'd1, 16'h0001, 1'b0, 3'd2, 3'd1, 16'h7FFF, 16'h8000};
    vecs[8]  = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 3'd1, 16'h8000, 16'h0001};
    vecs[9]  = '{1'b1, 1'b1, 3'd4, 16'h00AA, 1'b0, 3'd4, 3'd4, 16'h8000, 16'h0001};
    vecs[10] = '{1'b1, 1'b1, 3'd4, 16'h0055, 1'b1, 3'd4, 3'd4, exp_same, exp_same};
    vecs[11] = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 3'd4, 16'h0055, 16'h0055};
    vecs[12] = '{1'b1, 1'b1, 3'd7, 16'hBEEF, 1'b1, 3'd6, 3'd7, 16'h0000, 16'h0000};
    vecs[13] = '{1'b1, 1'b1, 3'd6, 16'h1111, 1'b1, 3'd7, 3'd6, 16'h0000, 16'h0000};

    // Register contents expected after the vector table has been applied.
    exp_rb = '{16'h0000, 16'h0001, 16'h8000, 16'h0000, 16'h0055, 16'h0000};

    rst_n = 1'b0; write_en = 1'b0; write_addr = '0; write_data = '0;
    read_en = 1'b0; read_addr_a = '0; read_addr_b = '0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      step(vecs[i].rst_n, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra, vecs[i].rb);
      check($sformatf("vec%0d_out_a", i), out_a, vecs[i].ea);
      check($sformatf("vec%0d_out_b", i), out_b, vecs[i].eb);
    end

    // Read every register back to confirm that the out-of-range writes did not change r0..r5.
    for (int i = 0; i < N_REGS; i += 2) begin
      step(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, AW'(i), AW'(i + 1));
      check($sformatf("readback_r%0d", i), out_a, exp_rb[i]);
      check($sformatf("readback_r%0d", i + 1), out_b, exp_rb[i + 1]);
    end

    // ALU add loop. Register r0 is an ordinary writable register.
    step(1'b1, 1'b1, 3'd0, 16'd5, 1'b0, 3'd0, 3'd1);
    step(1'b1, 1'b1, 3'd1, 16'hFFFD, 1'b0, 3'd0, 3'd1);
    step(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 3'd1);
    check("alu_r0", out_a, 16'h0005);
    check("alu_r1", out_b, 16'hFFFD);
    sum = out_a + out_b;
    step(1'b1, 1'b1, 3'd2, sum, 1'b0, 3'd2, 3'd1);
    step(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 3'd1);
    check("alu_r2_first", out_a, 16'h0002);
    for (int k = 1; k <= 4; k++) begin
      sum = out_a + out_b;
      step(1'b1, 1'b1, 3'd2, sum, 1'b0, 3'd2, 3'd1);
      step(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 3'd1);
      check($sformatf("alu_r2_iter%0d", k), out_a, 16'(2 - 3 * k));
    end
    check("alu_r2_final", out_a, 16'hFFF6);

    // A reset asserted in the middle of a sequence discards the pending write and the pending read update.
    step(1'b0, 1'b1, 3'd2, 16'h4321, 1'b1, 3'd2, 3'd1);
    check("midreset_a", out_a, 16'h0000);
    check("midreset_b", out_b, 16'h0000);
    step(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 3'd1);
    check("midreset_r2", out_a, 16'h0000);
    check("midreset_r1", out_b, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_operand_regfile.md
Name: alu_operand_regfile

Overview:
- Register file directly upstream of the ALU; supplies both signed operands (in_a, in_b) and accepts the ALU result as write-back data.
- Two read ports with registered, 1-cycle-latency outputs; one synchronous write port.
- Read-enable lets the controller hold operands stable across multi-cycle ALU use.

Parameters:
- BW, 16, data bitwidth; must equal the ALU BW.
- N_REGS, 8, number of registers; any value >= 2, power of two not required.
- ADDR_W, $clog2(N_REGS), address width; derived, never overridden.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- write_en  input  1  write strobe.
- write_addr  input  ADDR_W  write register index.
- write_data  input  BW (signed)  write data, normally the ALU out.
- read_en  input  1  update enable for both read output registers.
- read_addr_a  input  ADDR_W  port A register index.
- read_addr_b  input  ADDR_W  port B register index.
- out_a  output  BW (signed)  operand A; drives ALU in_a.
- out_b  output  BW (signed)  operand B; drives ALU in_b.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset, when rst_n = 0 at a rising edge:
  - all N_REGS registers become 0;
  - out_a and out_b become 0;
  - any write_en in that same cycle is discarded.
- Reset is the only way to clear storage. Asserting reset mid-sequence discards any in-flight write and the pending read update.
- Write, when rst_n = 1, write_en = 1 and write_addr < N_REGS:
  - mem[write_addr] <= write_data at the rising edge;
  - the new value is visible to reads sampled from the next cycle on.
- Write with write_addr >= N_REGS: ignored; no register changes.
- Read, when rst_n = 1 and read_en = 1:
  - out_a <= mem[read_addr_a] and out_b <= mem[read_addr_b] at the rising edge;
  - latency is exactly 1 cycle from address presentation to valid output.
- Read with an address >= N_REGS: that port loads 0.
- read_en = 0: out_a and out_b hold their previous values, regardless of address changes or writes to the addressed registers.
- Both ports may address the same register; both outputs then load the same value.
- Simultaneous read and write of the same index in one cycle, without the optional feature: the read port loads the pre-write (old) value, and the write still completes.
- Register 0 is an ordinary writable register; there is no hardwired zero.
- No combinational path from any input to out_a or out_b; both outputs come straight from flops.
- Signed storage only; no width conversion; write_data is stored bit-exact.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: write-to-read forwarding. When write_en = 1, write_addr < N_REGS and read_en = 1:
  - a read port whose address equals write_addr loads write_data (new value) instead of the stored value;
  - this applies independently to port A and port B;
  - the register write happens as usual.
  - Lets a back-to-back dependent ALU operation use its result one cycle earlier.
- Undefined: old-value behaviour as described in Behaviour; no forwarding mux is synthesised.

Test Plan:
- Reset: write 0x1234 to r3, assert rst_n = 0 for 1 cycle together with write_en = 1 (r5 <= 0x7777) -> afterwards r3 and r5 read 0x0000; out_a and out_b = 0 in the cycle after reset.
- Basic write/read: write r1 = 0x7FFF, r2 = 0x8000 (-32768), then read_addr_a = 1, read_addr_b = 2 with read_en = 1 -> one cycle later out_a = 0x7FFF and out_b = 0x8000; nothing is valid in the same cycle.
- Hold: with out_a = 0x7FFF, set read_en = 0, change read_addr_a = 2 and write r1 = 0x0001 -> out_a stays 0x7FFF; after read_en = 1 -> out_a = 0x8000.
- Same-cycle read/write on r4 (old 0x00AA, new 0x0055), both ports addressing r4:
  - without RF_BYPASS_EN -> out_a = out_b = 0x00AA, next read gives 0x0055;
  - with RF_BYPASS_EN -> out_a = out_b = 0x0055.
- Out of range, with N_REGS = 6: write addr 7 = 0xBEEF, read addr 6 and 7 -> outputs 0x0000; all r0..r5 unchanged, checked by a full readback.
- ALU loop: r0 = 5, r1 = -3, feed out_a/out_b into an ALU performing add and write the result back to r2 -> r2 reads 0x0002; repeat 4 times (r2 = r2 + r1) -> r2 = 0xFFF6 (-10).
